// File: rtl/rggen_host_if_axi4lite_buffered_if.sv
// AXI4-Lite slave channels plus the flat register-bus command/response port.
interface rggen_host_if_axi4lite_buffered_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  localparam int STROBE_WIDTH = DATA_WIDTH / 8;

  logic                     awvalid;
  logic                     awready;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic                     wvalid;
  logic                     wready;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [STROBE_WIDTH-1:0]  wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic                     rvalid;
  logic                     rready;
  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;
  logic                     bus_request;
  logic                     bus_direction;
  logic [ADDRESS_WIDTH-1:0] bus_address;
  logic [DATA_WIDTH-1:0]    bus_write_data;
  logic [STROBE_WIDTH-1:0]  bus_strobe;
  logic                     bus_done;
  logic [DATA_WIDTH-1:0]    bus_read_data;
  logic [1:0]               bus_status;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output bus_request, bus_direction, bus_address, bus_write_data, bus_strobe,
    input  bus_done, bus_read_data, bus_status
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    input  bus_request, bus_direction, bus_address, bus_write_data, bus_strobe,
    output bus_done, bus_read_data, bus_status
  );
endinterface

// File: rtl/rggen_host_if_axi4lite_buffered.sv
// Buffered AXI4-Lite slave to flat register-bus bridge with write/read/round-robin
// arbitration and an optional bus-response timeout that answers SLVERR.
module rggen_host_if_axi4lite_buffered #(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int ACCESS_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input logic clk,
  input logic rst_n,
  rggen_host_if_axi4lite_buffered_if.slave port
);
  localparam int          STROBE_WIDTH   = DATA_WIDTH / 8;
  localparam bit          TIMEOUT_ENABLE = TIMEOUT_CYCLES != 0;
  localparam logic [16:0] TIMEOUT_LIMIT  = 17'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, WR_BUSY, RD_BUSY, WAIT_B, WAIT_R} state_e;
  state_e state, state_next;

  logic                     aw_full, w_full, ar_full;
  logic [ADDRESS_WIDTH-1:0] aw_addr, ar_addr, cmd_address;
  logic [DATA_WIDTH-1:0]    w_data, cmd_write_data, rdata_q;
  logic [STROBE_WIDTH-1:0]  w_strb, cmd_strobe;
  logic                     cmd_direction, last_write;
  logic [1:0]               bresp_q, rresp_q;
  logic [16:0]              count;
  logic                     wr_pend, rd_pend, grant_wr, grant_rd;
  logic                     busy, done, timeout;

  assign wr_pend = aw_full && w_full;
  assign rd_pend = ar_full;
  assign busy    = (state == WR_BUSY) || (state == RD_BUSY);
  assign done    = busy && port.bus_done;
  assign timeout = TIMEOUT_ENABLE && busy && ((count + 17'd1) == TIMEOUT_LIMIT);

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE) begin
      if (wr_pend && rd_pend) begin
        if (ACCESS_PRIORITY == 0)      grant_wr = 1'b1;
        else if (ACCESS_PRIORITY == 1) grant_rd = 1'b1;
        else if (last_write)           grant_rd = 1'b1;
        else                           grant_wr = 1'b1;
      end else begin
        grant_wr = wr_pend;
        grant_rd = rd_pend;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_wr)      state_next = WR_BUSY;
        else if (grant_rd) state_next = RD_BUSY;
      end
      WR_BUSY: if (done || timeout) state_next = WAIT_B;
      RD_BUSY: if (done || timeout) state_next = WAIT_R;
      WAIT_B:  if (port.bready) state_next = IDLE;
      WAIT_R:  if (port.rready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    port.bus_request = 1'b0;
    port.bvalid      = 1'b0;
    port.rvalid      = 1'b0;
    case (state)
      WR_BUSY, RD_BUSY: port.bus_request = 1'b1;
      WAIT_B:           port.bvalid      = 1'b1;
      WAIT_R:           port.rvalid      = 1'b1;
      default: ;
    endcase
  end

  // Buffers refill while the bus is busy; a grant empties them so ready returns next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_full <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (grant_wr) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (port.awvalid && !aw_full) begin
          aw_full <= 1'b1;
          aw_addr <= port.awaddr;
        end
        if (port.wvalid && !w_full) begin
          w_full <= 1'b1;
          w_data <= port.wdata;
          w_strb <= port.wstrb;
        end
      end
      if (grant_rd) begin
        ar_full <= 1'b0;
      end else if (port.arvalid && !ar_full) begin
        ar_full <= 1'b1;
        ar_addr <= port.araddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_direction  <= 1'b0;
      cmd_address    <= '0;
      cmd_write_data <= '0;
      cmd_strobe     <= '0;
      last_write     <= 1'b0;
    end else if (grant_wr) begin
      cmd_direction  <= 1'b1;
      cmd_address    <= aw_addr;
      cmd_write_data <= w_data;
      cmd_strobe     <= w_strb;
      last_write     <= 1'b1;
    end else if (grant_rd) begin
      cmd_direction  <= 1'b0;
      cmd_address    <= ar_addr;
      last_write     <= 1'b0;
    end
  end

  // bus_done takes precedence over a timeout landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      bresp_q <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
    end else begin
      if (grant_wr || grant_rd) count <= '0;
      else if (busy)            count <= count + 17'd1;
      if ((state == WR_BUSY) && (done || timeout)) begin
        bresp_q <= done ? port.bus_status : 2'b10;
      end
      if ((state == RD_BUSY) && (done || timeout)) begin
        rresp_q <= done ? port.bus_status : 2'b10;
        rdata_q <= done ? port.bus_read_data : '0;
      end
    end
  end

  assign port.awready        = !aw_full;
  assign port.wready         = !w_full;
  assign port.arready        = !ar_full;
  assign port.bresp          = bresp_q;
  assign port.rresp          = rresp_q;
  assign port.rdata          = rdata_q;
  assign port.bus_direction  = cmd_direction;
  assign port.bus_address    = cmd_address;
  assign port.bus_write_data = cmd_write_data;
  assign port.bus_strobe     = cmd_strobe;
endmodule

// File: tb/tb_rggen_host_if_axi4lite_buffered.sv
// Scoreboard bench: stimulus pushes expected B/R responses, a negedge monitor pops and compares.
module tb_rggen_host_if_axi4lite_buffered;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int PRIO = 2;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rggen_host_if_axi4lite_buffered_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) port ();

  rggen_host_if_axi4lite_buffered #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_PRIORITY(PRIO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .port(port)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_b[$];
  exp_t        exp_r[$];
  logic [31:0] ref_mem [256];
  logic [31:0] bus_mem [256];
  int          force_delay = -1;
  bit          noise_en = 1'b0;
  int          ready_mode = 1;
  int          req_len = 0;
  int          last_req_len = 0;
  bit          req_active = 1'b0;
  int          wait_left = 0;
  bit          log_en = 1'b0;
  logic        grant_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Environment: addresses with top nibble F never answer; others return status addr[13:12].
  function automatic logic [1:0] model_resp(input logic [15:0] a);
    if (a[15:12] == 4'hF) return 2'b10;
    return a[13:12];
  endfunction

  task automatic push_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.resp = model_resp(a);
    e.data = '0;
    exp_b.push_back(e);
    if (a[15:12] != 4'hF) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, s);
  endtask

  task automatic push_read(input logic [15:0] a);
    exp_t e;
    e.resp = model_resp(a);
    e.data = (a[15:12] == 4'hF) ? 32'h0 : ref_mem[a[9:2]];
    exp_r.push_back(e);
  endtask

  task automatic send_aw(input logic [15:0] a);
    bit ok = 1'b0;
    port.awvalid = 1'b1;
    port.awaddr  = a;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk); ok = port.awready;
      @(posedge clk); #1;
    end
    port.awvalid = 1'b0;
    if (!ok) check("aw_handshake_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    port.wvalid = 1'b1;
    port.wdata  = d;
    port.wstrb  = s;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk); ok = port.wready;
      @(posedge clk); #1;
    end
    port.wvalid = 1'b0;
    if (!ok) check("w_handshake_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_ar(input logic [15:0] a);
    bit ok = 1'b0;
    port.arvalid = 1'b1;
    port.araddr  = a;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk); ok = port.arready;
      @(posedge clk); #1;
    end
    port.arvalid = 1'b0;
    if (!ok) check("ar_handshake_timeout", 64'(ok), 64'd1);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) check("drain_timeout", 64'(exp_b.size() + exp_r.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 64'(port.awready), 64'd1);
    check({tag, "_wready"}, 64'(port.wready), 64'd1);
    check({tag, "_arready"}, 64'(port.arready), 64'd1);
    check({tag, "_bvalid"}, 64'(port.bvalid), 64'd0);
    check({tag, "_rvalid"}, 64'(port.rvalid), 64'd0);
    check({tag, "_bus_request"}, 64'(port.bus_request), 64'd0);
    check({tag, "_bus_direction"}, 64'(port.bus_direction), 64'd0);
    check({tag, "_bus_address"}, 64'(port.bus_address), 64'd0);
    check({tag, "_bus_write_data"}, 64'(port.bus_write_data), 64'd0);
    check({tag, "_bus_strobe"}, 64'(port.bus_strobe), 64'd0);
    check({tag, "_rdata"}, 64'(port.rdata), 64'd0);
    check({tag, "_bresp"}, 64'(port.bresp), 64'd0);
    check({tag, "_rresp"}, 64'(port.rresp), 64'd0);
  endtask

  // B/R ready driver: 0 random, 1 always ready, 2 rready held low.
  initial begin
    port.bready = 1'b0;
    port.rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: begin
          port.bready = ($urandom_range(0, 3) != 0);
          port.rready = ($urandom_range(0, 3) != 0);
        end
        1: begin port.bready = 1'b1; port.rready = 1'b1; end
        default: begin port.bready = 1'b1; port.rready = 1'b0; end
      endcase
    end
  end

  // Register-bus responder with its own memory and optional stray bus_done noise.
  initial begin
    logic [7:0] idx;
    port.bus_done      = 1'b0;
    port.bus_read_data = '0;
    port.bus_status    = '0;
    forever begin
      @(posedge clk); #1;
      port.bus_done      = 1'b0;
      port.bus_read_data = $urandom;
      port.bus_status    = 2'($urandom_range(0, 3));
      if (port.bus_request === 1'b1) begin
        if (!req_active) begin
          req_active = 1'b1;
          req_len = 0;
          if (log_en) grant_log.push_back(port.bus_direction);
          wait_left = (force_delay >= 0) ? force_delay : $urandom_range(0, 3);
          if (port.bus_address[15:12] == 4'hF) wait_left = 1 << 30;
        end
        req_len++;
        if (wait_left == 0) begin
          idx = port.bus_address[9:2];
          if (port.bus_direction)
            bus_mem[idx] = merge(bus_mem[idx], port.bus_write_data, port.bus_strobe);
          else
            port.bus_read_data = bus_mem[idx];
          port.bus_status = port.bus_address[13:12];
          port.bus_done   = 1'b1;
        end else begin
          wait_left--;
        end
      end else begin
        if (req_active) last_req_len = req_len;
        req_active = 1'b0;
        if (noise_en && $urandom_range(0, 3) == 0) port.bus_done = 1'b1;
      end
    end
  end

  // Monitor: pops expectations on each B/R handshake and checks stalled responses hold.
  exp_t        e_mon;
  bit          b_stall = 1'b0, r_stall = 1'b0;
  logic [1:0]  b_prev_resp, r_prev_resp;
  logic [31:0] r_prev_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      b_stall = 1'b0;
      r_stall = 1'b0;
    end else begin
      if (b_stall) begin
        check("bvalid_held", 64'(port.bvalid), 64'd1);
        check("bresp_held", 64'(port.bresp), 64'(b_prev_resp));
      end
      if (r_stall) begin
        check("rvalid_held", 64'(port.rvalid), 64'd1);
        check("rresp_held", 64'(port.rresp), 64'(r_prev_resp));
        check("rdata_held", 64'(port.rdata), 64'(r_prev_data));
      end
      if (port.bvalid && port.bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 64'(port.bvalid), 64'd0);
        else begin
          e_mon = exp_b.pop_front();
          check("bresp", 64'(port.bresp), 64'(e_mon.resp));
        end
      end
      if (port.rvalid && port.rready) begin
        if (exp_r.size() == 0) check("r_unexpected", 64'(port.rvalid), 64'd0);
        else begin
          e_mon = exp_r.pop_front();
          check("rresp", 64'(port.rresp), 64'(e_mon.resp));
          check("rdata", 64'(port.rdata), 64'(e_mon.data));
        end
      end
      b_stall = port.bvalid && !port.bready;
      r_stall = port.rvalid && !port.rready;
      b_prev_resp = port.bresp;
      r_prev_resp = port.rresp;
      r_prev_data = port.rdata;
    end
  end

  initial begin
    #300000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, wa, ra;
    logic [31:0] d;
    logic [3:0]  s;
    int          g1, g2, n;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
      bus_mem[i] = ref_mem[i];
    end
    port.awvalid = 1'b0; port.awaddr = '0;
    port.wvalid  = 1'b0; port.wdata  = '0; port.wstrb = '0;
    port.arvalid = 1'b0; port.araddr = '0;

    // Reset state
    rst_n = 1'b0;
    step(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step(1);

    // AW at t0, W three cycles later, bus_done two cycles into the request
    force_delay = 2;
    a = 16'h0010; d = 32'hCAFE_BABE; s = 4'b1011;
    push_write(a, d, s);
    send_aw(a);
    repeat (2) begin
      check("t1_awready_full", 64'(port.awready), 64'd0);
      check("t1_wready_open", 64'(port.wready), 64'd1);
      step(1);
    end
    send_w(d, s);
    check("t1_wready_low", 64'(port.wready), 64'd0);
    check("t1_req_not_yet", 64'(port.bus_request), 64'd0);
    step(1);
    check("t1_bus_request", 64'(port.bus_request), 64'd1);
    check("t1_bus_direction", 64'(port.bus_direction), 64'd1);
    check("t1_bus_address", 64'(port.bus_address), 64'(a));
    check("t1_bus_write_data", 64'(port.bus_write_data), 64'(d));
    check("t1_bus_strobe", 64'(port.bus_strobe), 64'(s));
    check("t1_wready_back", 64'(port.wready), 64'd1);
    drain();
    check("t1_req_len", 64'(last_req_len), 64'd3);

    // Timeout: no bus_done ever, then bus_done landing exactly on the timeout cycle
    force_delay = -1;
    push_read(16'hF040);
    send_ar(16'hF040);
    drain();
    check("t4_read_req_len", 64'(last_req_len), 64'(TMO));
    push_write(16'hF044, 32'h1234_5678, 4'hF);
    fork send_aw(16'hF044); send_w(32'h1234_5678, 4'hF); join
    drain();
    check("t4_write_req_len", 64'(last_req_len), 64'(TMO));
    force_delay = TMO - 1;
    push_read(16'h0010);
    send_ar(16'h0010);
    drain();
    check("t4_done_wins_len", 64'(last_req_len), 64'(TMO));
    force_delay = -1;

    // DECERR read held by rready low for 5 cycles; next AR accepted meanwhile
    ready_mode = 2;
    push_read(16'h3020);
    send_ar(16'h3020);
    n = 0;
    while (!port.rvalid && n < 50) begin step(1); n++; end
    check("t5_rvalid_seen", 64'(port.rvalid), 64'd1);
    push_read(16'h0024);
    send_ar(16'h0024);
    check("t5_ar_captured", 64'(port.arready), 64'd0);
    step(3);
    check("t5_rvalid_still", 64'(port.rvalid), 64'd1);
    ready_mode = 1;
    drain();

    // Reset while in RD_BUSY discards the read
    send_ar(16'hF050);
    n = 0;
    while (!port.bus_request && n < 20) begin step(1); n++; end
    check("t6_in_busy", 64'(port.bus_request), 64'd1);
    rst_n = 1'b0;
    step(1);
    check_reset_outputs("t6");
    rst_n = 1'b1;
    step(12);
    check("t6_no_rvalid", 64'(port.rvalid), 64'd0);
    check("t6_no_request", 64'(port.bus_request), 64'd0);

    // Round-robin after reset: four back-to-back write+read pairs alternate starting with write
    log_en = 1'b1;
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      wa = 16'h0100 + 16'(4 * k);
      ra = 16'h0200 + 16'(4 * k);
      d  = $urandom;
      push_write(wa, d, 4'hF);
      push_read(ra);
      fork send_aw(wa); send_w(d, 4'hF); send_ar(ra); join
    end
    drain();
    log_en = 1'b0;
    check("t3_grant_count", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check($sformatf("t3_grant_%0d", k), 64'(grant_log[k]), 64'((k % 2) == 0));

    // Randomized traffic with random ready, stray bus_done and occasional timeouts
    ready_mode = 0;
    noise_en = 1'b1;
    for (int t = 0; t < 60; t++) begin
      a = {2'b00, 2'($urandom_range(0, 3)), 2'b00, 8'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 9) == 0) a[15:12] = 4'hF;
      if ($urandom_range(0, 1) == 1) begin
        d  = $urandom;
        s  = 4'($urandom_range(0, 15));
        g1 = $urandom_range(0, 3);
        g2 = $urandom_range(0, 3);
        push_write(a, d, s);
        fork
          begin step(g1); send_aw(a); end
          begin step(g2); send_w(d, s); end
        join
      end else begin
        push_read(a);
        send_ar(a);
      end
      drain();
    end
    noise_en = 1'b0;
    ready_mode = 1;
    drain();
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
